onehot_pulse_decoder: RTL and testbench
=======================================

# onehot_pulse_decoder

Sequential 3-to-8 decoder that turns an encoded line index back into a one-hot drive. It accepts a 3-bit code over a valid/ready handshake and asserts the matching output line for a programmable number of cycles. It then enforces a programmable idle gap before accepting the next code. It sits downstream of the team's 8-to-3 priority encoder, re-expanding its index into per-line strobes for actuators and LED banks.

## Interface
- HOLD_CYCLES, 4, cycles the one-hot output is driven per accepted code; legal range 1..255.
- GAP_CYCLES, 1, idle cycles forced after each hold; legal range 0..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low aborts any activity.
- code_valid  input  1  `code` is valid this cycle.
- code  input  3  line index to assert; 0 selects y[0] and 7 selects y[7].
- code_ready  output  1  block can accept a code this cycle.
- y  output  8  one-hot drive, registered.
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse when a hold completes normally.

## Operation
- FSM states: IDLE, HOLD, GAP.
- Counter width: 8 bits, unsigned. It loads N-1 and decrements to 0.
- `code_ready` is combinational and equals `(state==IDLE) && en`.
- Accept occurs when `code_valid && code_ready` at a rising edge. In the same edge:
  - state becomes HOLD;
  - `y` becomes `8'b1 << code`;
  - cnt loads HOLD_CYCLES-1.
- HOLD, `en` high, cnt≠0: cnt decrements and `y` holds.
- HOLD, `en` high, cnt==0: `done` pulses for 1 cycle and `y` goes idle. The next state is:
  - GAP with cnt = GAP_CYCLES-1 when GAP_CYCLES>0;
  - IDLE when GAP_CYCLES==0.
- GAP, `en` high: cnt decrements. When cnt==0, the next state is IDLE.
- `en` low in any state: next edge goes to IDLE, `y` goes idle and `done` stays 0. An aborted hold never pulses `done`.
- `code_valid` with `code_ready` low is ignored. The code is not stored; the source must hold it.
- `code` is sampled only on the accept edge. Later changes to `code` do not affect `y`.
- `busy` is registered and equals `(state != IDLE)`.
- `y` has at most one bit set at any time.

## Timing
- Reset values:
  - state = IDLE, cnt = 0;
  - `y` = idle value (see Configuration);
  - `busy` = 0, `done` = 0;
  - `code_ready` = `en`.
- Latency: `y` is valid 1 cycle after the accept edge and is driven for exactly HOLD_CYCLES cycles.
- `done` is high in the first cycle after the last hold cycle, i.e. the cycle where `y` first returns to idle.
- Minimum accept-to-accept spacing is HOLD_CYCLES + GAP_CYCLES + 1 cycles. With the defaults this is 6.
- Reset asserted mid-hold clears all outputs immediately, without waiting for a clock edge.

## Configuration
- Macro: DEC_TRISTATE_IDLE_EN.
- Defined: the idle value of `y` is `8'bzzzzzzzz` in IDLE, GAP, during `en` low and during reset. This lets several decoders share one bus.
- Undefined: the idle value of `y` is `8'h00`.
- All other behaviour is identical in both builds.

## Test plan
- Reset then accept with defaults: pulse `rst`, set `en`=1, present `code`=5 with `code_valid` → `y`=8'h20 for 4 cycles. Then `done`=1 for 1 cycle with `y` idle, a 1-cycle GAP, then `code_ready`=1.
- All codes: sweep `code` 0..7 back-to-back with `code_valid` held high → `y` = 01, 02, 04 … 80. Accepts are spaced exactly 6 cycles apart and `y` is never multi-hot.
- Abort: `en`→0 on the 2nd hold cycle of `code`=3 → `y` idle on the next edge, `done` never pulses, state is IDLE. `en`=1 then gives `code_ready`=1 immediately.
- Boundary parameters: HOLD_CYCLES=1, GAP_CYCLES=0, `code`=7 → `y`=8'h80 for exactly 1 cycle. `done` pulses and the next code is accepted in the same cycle as `done`.
- Async reset mid-hold: assert `rst` between edges during a hold of `code`=2 → `y`, `busy` and `done` are cleared before the next edge. Check the idle value in both DEC_TRISTATE_IDLE_EN builds: z vs 00.
- Ignored input: `code_valid` pulsed with `code`=6 during GAP → no effect on `y`. Changing `code` mid-hold leaves `y` unchanged.

Source files
------------

// File: rtl/onehot_pulse_decoder_if.sv
// Handshake and drive bundle for onehot_pulse_decoder.
// master = code source, slave = decoder.
interface onehot_pulse_decoder_if;
    logic       en;
    logic       code_valid;
    logic [2:0] code;
    logic       code_ready;
    logic [7:0] y;
    logic       busy;
    logic       done;

    modport master (
        output en, code_valid, code,
        input  code_ready, y, busy, done
    );

    modport slave (
        input  en, code_valid, code,
        output code_ready, y, busy, done
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Sequential 3-to-8 decoder: drives y[code] for HOLD_CYCLES, then idles GAP_CYCLES.
// Build option: define DEC_TRISTATE_IDLE_EN to float y (8'bz) instead of 8'h00 when idle.
module onehot_pulse_decoder #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input logic                    clk,
    input logic                    rst,
    onehot_pulse_decoder_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GapLoad  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            y_q     <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        if (!bus.en) begin
            // Abort: drop everything without signalling completion.
            state_d = StIdle;
            cnt_d   = 8'd0;
            y_d     = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.code_valid) begin
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                        y_d     = 8'd1 << bus.code;
                    end
                end
                StHold: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        done_d = 1'b1;
                        y_d    = 8'd0;
                        if (GAP_CYCLES > 0) begin
                            state_d = StGap;
                            cnt_d   = GapLoad;
                        end else begin
                            state_d = StIdle;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                StGap: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    y_d     = 8'd0;
                end
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    assign bus.code_ready = (state_q == StIdle) && bus.en;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // y_q is non-zero only while a hold is in progress.
`ifdef DEC_TRISTATE_IDLE_EN
    assign bus.y = (y_q != 8'd0) ? y_q : 8'bzzzzzzzz;
`else
    assign bus.y = y_q;
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: default DUT (4/1) and boundary DUT (1/0) share stimulus.
module tb_onehot_pulse_decoder;

`ifdef DEC_TRISTATE_IDLE_EN
    localparam logic [7:0] IDLE_Y = 8'bzzzzzzzz;
`else
    localparam logic [7:0] IDLE_Y = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en_s, valid_s;
    logic [2:0] code_s;

    onehot_pulse_decoder_if ifa ();
    onehot_pulse_decoder_if ifb ();

    assign ifa.en = en_s;
    assign ifa.code_valid = valid_s;
    assign ifa.code = code_s;
    assign ifb.en = en_s;
    assign ifb.code_valid = valid_s;
    assign ifb.code = code_s;

    onehot_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    onehot_pulse_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: remaining drive/gap cycles per DUT.
    int         hold_p [2] = '{4, 1};
    int         gap_p  [2] = '{1, 0};
    int         hold_left [2];
    int         gap_left  [2];
    logic [2:0] code_lat  [2];
    logic       done_m    [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hold_left[i] = 0;
            gap_left[i]  = 0;
            code_lat[i]  = 3'd0;
            done_m[i]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!en_s) begin
                hold_left[i] = 0;
                gap_left[i]  = 0;
                done_m[i]    = 1'b0;
            end else if (hold_left[i] > 0) begin
                hold_left[i]--;
                done_m[i] = (hold_left[i] == 0);
                if (hold_left[i] == 0) gap_left[i] = gap_p[i];
            end else if (gap_left[i] > 0) begin
                gap_left[i]--;
                done_m[i] = 1'b0;
            end else begin
                done_m[i] = 1'b0;
                if (valid_s) begin
                    hold_left[i] = hold_p[i];
                    code_lat[i]  = code_s;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_y(input int i);
        logic [7:0] one;
        one = 8'd1;
        return (hold_left[i] > 0) ? (one << code_lat[i]) : IDLE_Y;
    endfunction

    function automatic logic exp_ready(input int i);
        return en_s && hold_left[i] == 0 && gap_left[i] == 0;
    endfunction

    task automatic check_all();
        chk("a_y", ifa.y, exp_y(0));
        chk("a_busy", {7'd0, ifa.busy}, {7'd0, (hold_left[0] > 0 || gap_left[0] > 0)});
        chk("a_done", {7'd0, ifa.done}, {7'd0, done_m[0]});
        chk("a_ready", {7'd0, ifa.code_ready}, {7'd0, exp_ready(0)});
        chk("b_y", ifb.y, exp_y(1));
        chk("b_busy", {7'd0, ifb.busy}, {7'd0, (hold_left[1] > 0 || gap_left[1] > 0)});
        chk("b_done", {7'd0, ifb.done}, {7'd0, done_m[1]});
        chk("b_ready", {7'd0, ifb.code_ready}, {7'd0, exp_ready(1)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        int last_acc;
        bit got;
        rst = 1'b1; en_s = 1'b0; valid_s = 1'b0; code_s = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        en_s = 1'b1;
        #1;
        check_all();
        chk("rst_ready_eq_en", {7'd0, ifa.code_ready}, 8'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single accept of code 5 with defaults.
        code_s = 3'd5; valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        chk("t1_y_first", ifa.y, 8'h20);
        repeat (3) tick();
        chk("t1_y_last", ifa.y, 8'h20);
        tick();
        chk("t1_done", {7'd0, ifa.done}, 8'd1);
        chk("t1_y_idle", ifa.y, IDLE_Y);
        tick();
        chk("t1_ready", {7'd0, ifa.code_ready}, 8'd1);
        repeat (2) tick();

        // Sweep all codes back to back; accepts on the default DUT must be 6 apart.
        valid_s = 1'b1;
        last_acc = 0;
        for (int c = 0; c < 8; c++) begin
            code_s = 3'(c);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                #1;
                if (ifa.code_ready) begin
                    got = 1'b1;
                    tick();
                    chk("sweep_y", ifa.y, 8'h01 << c);
                    if (c > 0) chk("sweep_spacing", 8'(cyc - last_acc), 8'd6);
                    last_acc = cyc;
                end else begin
                    tick();
                end
            end
            if (!got) chk("sweep_timeout", 8'd0, 8'd1);
        end
        valid_s = 1'b0;
        repeat (8) tick();

        // Abort on the 2nd hold cycle.
        code_s = 3'd3; valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        tick();
        en_s = 1'b0;
        tick();
        chk("abort_y", ifa.y, IDLE_Y);
        chk("abort_done", {7'd0, ifa.done}, 8'd0);
        chk("abort_busy", {7'd0, ifa.busy}, 8'd0);
        repeat (3) tick();
        en_s = 1'b1;
        #1;
        chk("abort_ready", {7'd0, ifa.code_ready}, 8'd1);
        tick();

        // Code changes mid-hold and a valid during GAP are ignored.
        code_s = 3'd1; valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        code_s = 3'd6;
        repeat (3) tick();
        chk("midhold_y", ifa.y, 8'h02);
        tick();
        valid_s = 1'b1; code_s = 3'd6;
        tick();
        valid_s = 1'b0;
        chk("gap_ignore_y", ifa.y, IDLE_Y);
        repeat (2) tick();
        chk("gap_ignore_y2", ifa.y, IDLE_Y);

        // Boundary DUT: 1-cycle hold, accept again in the done cycle.
        repeat (6) tick();
        code_s = 3'd7; valid_s = 1'b1;
        tick();
        chk("b_y_80", ifb.y, 8'h80);
        tick();
        chk("b_done_pulse", {7'd0, ifb.done}, 8'd1);
        chk("b_y_idle", ifb.y, IDLE_Y);
        chk("b_ready_at_done", {7'd0, ifb.code_ready}, 8'd1);
        tick();
        chk("b_reaccept", ifb.y, 8'h80);
        valid_s = 1'b0;
        repeat (6) tick();

        // Asynchronous reset between edges during a hold.
        code_s = 3'd2; valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        tick();
        chk("pre_rst_y", ifa.y, 8'h04);
        #2 rst = 1'b1;
        #1;
        chk("arst_y", ifa.y, IDLE_Y);
        chk("arst_busy", {7'd0, ifa.busy}, 8'd0);
        chk("arst_done", {7'd0, ifa.done}, 8'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            en_s    = ($urandom_range(0, 15) != 0);
            valid_s = $urandom_range(0, 1) == 1;
            code_s  = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
